// File: rtl/mult_acc_pkg.sv
// Shared constants and state type for the multiplier-product accumulator.
package mult_acc_pkg;

  localparam int P_W_DEFAULT   = 16;
  localparam int ACC_W_DEFAULT = 24;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: clamps to all-ones and flags the carry-out.
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         overflow
);

  logic [W:0] full;

  always_comb begin
    full     = {1'b0, a} + {1'b0, b};
    overflow = full[W];
    sum      = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/mult_product_accumulator.sv
// Accumulates a burst of unsigned products into a saturated sum and beat count,
// then holds the result until downstream takes it.
module mult_product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int P_W   = P_W_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);

  if (ACC_W < P_W) begin : g_bad_width
    $error("ACC_W must be at least P_W");
  end

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [ACC_W-1:0] product_ext;
  logic [ACC_W-1:0] sum_added;
  logic             sum_carry;
  logic [CNT_W-1:0] count_inc;
  logic             count_carry;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] count_next;
  logic             overflow_next;
  logic             valid_next;

  assign product_ext = ACC_W'(in_product);
  assign accept      = in_valid & in_ready;

  sat_add #(.W(ACC_W)) u_sum_add (
    .a        (out_sum),
    .b        (product_ext),
    .sum      (sum_added),
    .overflow (sum_carry)
  );

  sat_add #(.W(CNT_W)) u_count_add (
    .a        (out_count),
    .b        (CNT_W'(1)),
    .sum      (count_inc),
    .overflow (count_carry)
  );

  // Next-state decode; clear aborts from any state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_next = in_last ? HOLD : ACCUM;
        ACCUM:   if (accept && in_last) state_next = HOLD;
        HOLD:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / datapath decode. in_ready looks at state only, so there is
  // deliberately one bubble between a result leaving and the next beat.
  always_comb begin
    in_ready      = (state != HOLD);
    sum_next      = out_sum;
    count_next    = out_count;
    overflow_next = out_overflow;
    valid_next    = (state_next == HOLD);
    if (clear) begin
      sum_next      = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sum_next      = product_ext;
            count_next    = CNT_W'(1);
            overflow_next = 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_next      = sum_added;
            count_next    = count_carry ? out_count : count_inc;
            overflow_next = out_overflow | sum_carry;
          end
        end
        HOLD: begin
          if (out_ready) begin
            sum_next      = '0;
            count_next    = '0;
            overflow_next = 1'b0;
          end
        end
        default: begin
          sum_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      out_valid    <= valid_next;
      out_sum      <= sum_next;
      out_count    <= count_next;
      out_overflow <= overflow_next;
    end
  end

endmodule
